soc_mem_budget_arbiter: RTL and testbench
=========================================

// Module: soc_mem_budget_arbiter
// PURPOSE
// - Shares one memory-side port (HyperRAM AXI slave or LLC SPM) between the NrSlaves (11) crossbar masters.
// - Uses budgeted round-robin arbitration: each master gets a beat budget per regulation period.
// - Masters that have spent their budget are throttled, unless work-conserving mode is on.
// - Sits between the per-master request/len sideband and the shared port mux. Configured from the APB_SLVS register file.
// PARAMETERS
// - NumReq    11  number of requesters (ariane_soc::NrSlaves)
// - BudgetW   16  width of the per-requester beat budget counters
// - PeriodW   20  width of the regulation period counter
// - LenW      8   AXI burst length field width (beats-1)
// PORTS
// - clk_i          in   1               SoC clock
// - rst_i          in   1               async reset, active-high
// - en_i           in   1               0: no new grants are issued
// - cfg_wc_i       in   1               work-conserving: throttled masters may win when no master is in budget
// - cfg_period_i   in   PeriodW         regulation period, in cycles
// - cfg_budget_i   in   NumReq*BudgetW  beats allowed per period, per requester
// - req_i          in   NumReq          request pending, held until granted
// - len_i          in   NumReq*LenW     burst length (beats-1) of the pending request
// - beat_i         in   1               one data beat accepted on the shared port
// - last_i         in   1               qualifies beat_i as the final beat of the burst
// - gnt_o          out  NumReq          one-hot grant
// - gnt_valid_o    out  1               a grant is active
// - gnt_idx_o      out  $clog2(NumReq)  index of the granted requester
// - budget_o       out  NumReq*BudgetW  remaining budget, per requester (status)
// - throttled_o    out  NumReq          req_i high but over budget (status)
// BEHAVIOUR
// - Reset values: gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, all budgets=0, period counter=0, RR pointer=0, state=IDLE.
// - Period counter:
//   - When the counter is 0: reload to cfg_period_i and refill every budget from cfg_budget_i (refill pulse).
//   - Otherwise: decrement by 1 each cycle.
//   - The first refill happens on the first cycle after reset deasserts.
//   - cfg_period_i=0: refill every cycle, i.e. regulation is effectively off.
// - Eligibility:
//   - elig[n] = req_i[n] & (budget[n] >= len_i[n]+1). Compare at BudgetW+1 bits, with len zero-extended.
//   - If elig==0, req_i!=0 and cfg_wc_i=1: elig = req_i (bypass).
//   - throttled_o[n] = req_i[n] & ~(budget[n] >= len_i[n]+1). Combinational, independent of bypass.
// - FSM IDLE:
//   - If en_i and elig!=0: pick the first elig index at or after the RR pointer, with wrap-around.
//   - Register it into gnt_o/gnt_idx_o and set gnt_valid_o; go to BUSY.
//   - Latency: grant is visible 1 cycle after req_i rises.
// - FSM BUSY:
//   - Grant held stable.
//   - On beat_i&last_i: gnt_o=0, gnt_valid_o=0, RR pointer = winner+1 (winner=NumReq-1 wraps to 0); go to IDLE.
//   - At least one IDLE cycle always separates consecutive grants.
// - Charging:
//   - Each beat_i in BUSY decrements budget[winner] by 1, saturating at 0.
//   - A refill and a beat in the same cycle give budget = cfg_budget_i[winner]-1 (saturating). The refill is never lost.
// - en_i falling during BUSY: the burst completes normally; only new grants are blocked. The period counter keeps running.
// - cfg_* changes take effect at the next refill pulse (cfg_period_i at the next reload).
// - Illegal conditions (flagged by assertions; design behaviour still defined):
//   - beat_i in IDLE: ignored.
//   - req_i[winner] dropping in BUSY: grant is still held until last.
//   - len_i changing while req_i is high.
// - Reset mid-burst: all state is cleared immediately. The shared port mux must be reset in the same domain.
// STRUCTURE
// - ariane_soc package additions:
//   - localparams BudgetW, PeriodW.
//   - typedefs budget_t = logic [BudgetW-1:0] and budget_vec_t = budget_t [NrSlaves-1:0].
//   - MemBudgetDefault reset budget constant used by the register file.
// - Sub-module soc_budget_rr_pick: combinational rotate, find-first, un-rotate; outputs idx + valid. Reused by a per-LLC-partition variant.
// - Top holds the FSM, the period counter and the budget counters.
// TESTING
// - Basic grant: period=100, budgets=all 64, req_i[3] with len=7 -> gnt_o[3] 1 cycle later; 8 beats with last on beat 8 -> budget_o[3]=56, gnt released.
// - Round-robin: req 0,4,10 held with len=0 and single-beat bursts -> grant order 0,4,10,0; pointer wraps from 10 to 0.
// - Throttle: budget[2]=4, len=7, wc=0 -> throttled_o[2]=1 and no grant until refill, then gnt_o[2] 1 cycle after refill.
// - Work-conserving: same as throttle with wc=1 and no other requester -> granted; budget saturates at 0, not negative.
// - Refill/beat collision: beat on the refill-pulse cycle with budget cfg=64 -> budget_o=63.
// - Async reset mid-BUSY (beat 3 of 8) -> gnt_o=0, budgets=0 in the same cycle; first refill on the first cycle after release.

Source files
------------

// File: rtl/soc_mem_budget_arbiter_pkg.sv
// Shared types and constants for the budgeted round-robin memory-port arbiter.
package soc_mem_budget_arbiter_pkg;

  localparam int NrSlaves = 11;
  localparam int NumReq   = NrSlaves;
  localparam int BudgetW  = 16;
  localparam int PeriodW  = 20;
  localparam int LenW     = 8;
  localparam int IdxW     = $clog2(NumReq);
  localparam int CmpW     = BudgetW + 1;

  typedef logic [BudgetW-1:0]       budget_t;
  typedef budget_t [NrSlaves-1:0]   budget_vec_t;
  typedef logic [CmpW-1:0]          cmp_t;

  localparam budget_t MemBudgetDefault = budget_t'(64);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic budget_t sat_dec(input budget_t b);
    return (b == '0) ? '0 : b - budget_t'(1);
  endfunction

endpackage

// File: rtl/soc_budget_rr_pick.sv
// Round-robin pick: rotate requests so ptr_i is bit 0, find first set, map back to the absolute index.
module soc_budget_rr_pick #(
  parameter int N  = 11,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  localparam int SW = $clog2(2 * N);
  localparam logic [SW-1:0] NumV = SW'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SW-1:0]  ptr_x;
  logic [SW-1:0]  sum;
  logic [IW-1:0]  off;

  always_comb begin
    dbl   = {req_i, req_i};
    ptr_x = SW'(ptr_i);
    rot   = dbl[ptr_x +: N];
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = ptr_x + SW'(off);
    if (sum >= NumV) sum = sum - NumV;
    idx_o = IW'(sum);
    vld_o = |req_i;
  end

endmodule

// File: rtl/soc_mem_budget_arbiter.sv
// Budgeted round-robin arbiter for one shared memory port; each master may spend a beat budget per period.
// Grants are registered, held until the last beat, and always separated by at least one IDLE cycle.
module soc_mem_budget_arbiter
  import soc_mem_budget_arbiter_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      cfg_wc_i,
  input  logic [PeriodW-1:0]        cfg_period_i,
  input  logic [NumReq*BudgetW-1:0] cfg_budget_i,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq*LenW-1:0]    len_i,
  input  logic                      beat_i,
  input  logic                      last_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic                      gnt_valid_o,
  output logic [IdxW-1:0]           gnt_idx_o,
  output logic [NumReq*BudgetW-1:0] budget_o,
  output logic [NumReq-1:0]         throttled_o
);

  arb_state_e         state_q, state_d;
  logic [NumReq-1:0]  gnt_d;
  logic               gnt_valid_d;
  logic [IdxW-1:0]    gnt_idx_d, rr_ptr_q, rr_ptr_d;
  logic [PeriodW-1:0] period_q;
  budget_vec_t        budget_q, budget_d;
  logic               refill, charge;
  logic [NumReq-1:0]  fits, elig;
  logic               pick_vld;
  logic [IdxW-1:0]    pick_idx;

  assign refill = (period_q == '0);
  assign charge = (state_q == BUSY) && beat_i;

  always_comb begin
    fits = '0;
    for (int n = 0; n < NumReq; n++) begin
      fits[n] = cmp_t'(budget_q[n]) >= (cmp_t'(len_i[n*LenW +: LenW]) + cmp_t'(1));
    end
  end

  // Bypass lets throttled masters use the port only when nobody is in budget.
  always_comb begin
    elig = req_i & fits;
    if ((elig == '0) && (req_i != '0) && cfg_wc_i) elig = req_i;
  end

  assign throttled_o = req_i & ~fits;

  soc_budget_rr_pick #(
    .N  (NumReq),
    .IW (IdxW)
  ) u_pick (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_o;
    gnt_valid_d = gnt_valid_o;
    gnt_idx_d   = gnt_idx_o;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (en_i && pick_vld) begin
          state_d     = BUSY;
          gnt_d       = NumReq'(1) << pick_idx;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = pick_idx;
        end
      end
      BUSY: begin
        if (beat_i && last_i) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          rr_ptr_d    = (gnt_idx_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_o + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A charge on the refill cycle applies to the freshly loaded budget, so the refill is never lost.
  always_comb begin
    for (int n = 0; n < NumReq; n++) begin
      budget_d[n] = refill ? cfg_budget_i[n*BudgetW +: BudgetW] : budget_q[n];
      if (charge && (gnt_idx_o == IdxW'(n))) budget_d[n] = sat_dec(budget_d[n]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_o       <= '0;
      gnt_valid_o <= 1'b0;
      gnt_idx_o   <= '0;
      rr_ptr_q    <= '0;
      period_q    <= '0;
      budget_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_o       <= gnt_d;
      gnt_valid_o <= gnt_valid_d;
      gnt_idx_o   <= gnt_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      period_q    <= refill ? cfg_period_i : period_q - PeriodW'(1);
      budget_q    <= budget_d;
    end
  end

  assign budget_o = budget_q;

  a_beat_only_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    beat_i |-> (state_q == BUSY));
  a_winner_holds_req: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == BUSY) |-> req_i[gnt_idx_o]);
  for (genvar g = 0; g < NumReq; g++) begin : g_len_stable
    a_len_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i[g] && $past(req_i[g])) |-> (len_i[g*LenW +: LenW] == $past(len_i[g*LenW +: LenW])));
  end

endmodule

// File: tb/tb_soc_mem_budget_arbiter.sv
// Directed scenarios plus randomized traffic, all checked against a cycle-level behavioural model.
module tb_soc_mem_budget_arbiter;
  import soc_mem_budget_arbiter_pkg::*;

  localparam int BV = NumReq * BudgetW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en, wc, beat, last;
  logic [PeriodW-1:0]   cfg_period;
  logic [BV-1:0]        cfg_budget;
  logic [NumReq-1:0]    req;
  logic [NumReq*LenW-1:0] len;
  logic [NumReq-1:0]    gnt, throttled;
  logic                 gnt_valid;
  logic [IdxW-1:0]      gnt_idx;
  logic [BV-1:0]        budget;

  always #5 clk = ~clk;

  soc_mem_budget_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .cfg_wc_i     (wc),
    .cfg_period_i (cfg_period),
    .cfg_budget_i (cfg_budget),
    .req_i        (req),
    .len_i        (len),
    .beat_i       (beat),
    .last_i       (last),
    .gnt_o        (gnt),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx),
    .budget_o     (budget),
    .throttled_o  (throttled)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: m_* is what the registers hold now, x_* what they will hold after the next edge.
  int m_bud[NumReq];
  int x_bud[NumReq];
  int m_cnt, m_ptr, m_win, x_cnt, x_ptr, x_win;
  bit m_busy, x_busy;

  // Random traffic agent state.
  bit pend[NumReq];
  int plen[NumReq];
  int beats_done, rel_idx;
  bit last_sent;

  int rr_exp[4] = '{0, 4, 10, 0};

  task automatic check_eq(input string tag, input logic [BV-1:0] got, input logic [BV-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int len_of(int n);
    return int'(len[n*LenW +: LenW]);
  endfunction

  function automatic logic [NumReq-1:0] fits_vec();
    logic [NumReq-1:0] f;
    for (int n = 0; n < NumReq; n++) f[n] = (m_bud[n] >= len_of(n) + 1);
    return f;
  endfunction

  function automatic logic [NumReq-1:0] elig_vec();
    logic [NumReq-1:0] e;
    e = req & fits_vec();
    if (e == '0 && req != '0 && wc) e = req;
    return e;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NumReq; n++) begin
      m_bud[n] = 0;
      x_bud[n] = 0;
    end
    m_cnt = 0; m_ptr = 0; m_win = 0; m_busy = 0;
    x_cnt = 0; x_ptr = 0; x_win = 0; x_busy = 0;
  endtask

  task automatic model_next();
    bit refill;
    logic [NumReq-1:0] e;
    refill = (m_cnt == 0);
    x_cnt  = refill ? int'(cfg_period) : m_cnt - 1;
    for (int n = 0; n < NumReq; n++)
      x_bud[n] = refill ? int'(cfg_budget[n*BudgetW +: BudgetW]) : m_bud[n];
    if (m_busy && beat && x_bud[m_win] > 0) x_bud[m_win] = x_bud[m_win] - 1;
    x_busy = m_busy; x_win = m_win; x_ptr = m_ptr;
    if (!m_busy) begin
      e = elig_vec();
      if (en) begin
        for (int k = 0; k < NumReq; k++) begin
          if (e[(m_ptr + k) % NumReq]) begin
            x_busy = 1;
            x_win  = (m_ptr + k) % NumReq;
            break;
          end
        end
      end
    end else if (beat && last) begin
      x_busy = 0;
      x_ptr  = (m_win + 1) % NumReq;
    end
  endtask

  task automatic model_apply();
    m_bud = x_bud;
    m_cnt = x_cnt; m_ptr = x_ptr; m_win = x_win; m_busy = x_busy;
  endtask

  task automatic check_outputs(input string ph);
    logic [BV-1:0] eb;
    logic [NumReq-1:0] eg;
    for (int n = 0; n < NumReq; n++) eb[n*BudgetW +: BudgetW] = BudgetW'(m_bud[n]);
    eg = m_busy ? (NumReq'(1) << m_win) : '0;
    check_eq({ph, ":gnt"}, BV'(gnt), BV'(eg));
    check_eq({ph, ":gnt_valid"}, BV'(gnt_valid), BV'(m_busy));
    if (m_busy) check_eq({ph, ":gnt_idx"}, BV'(gnt_idx), BV'(m_win));
    check_eq({ph, ":budget"}, budget, eb);
    check_eq({ph, ":throttled"}, BV'(throttled), BV'(req & ~fits_vec()));
  endtask

  task automatic tick(input string ph);
    model_next();
    @(posedge clk);
    #1;
    model_apply();
    check_outputs(ph);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; beat = 1'b0; last = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    check_eq("reset:gnt_idx", BV'(gnt_idx), BV'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_drive();
    int skip;
    skip = -1;
    if (last_sent) begin
      pend[rel_idx] = 0; req[rel_idx] = 1'b0;
      skip = rel_idx; last_sent = 0; beats_done = 0;
    end
    for (int n = 0; n < NumReq; n++) begin
      if (!pend[n] && n != skip && $urandom_range(7) == 0) begin
        pend[n] = 1;
        plen[n] = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(2));
        req[n]  = 1'b1;
        len[n*LenW +: LenW] = LenW'(plen[n]);
      end
    end
    beat = 1'b0; last = 1'b0;
    if (m_busy && $urandom_range(3) != 0) begin
      beat = 1'b1;
      beats_done++;
      if (beats_done == plen[m_win] + 1) begin
        last = 1'b1; last_sent = 1; rel_idx = m_win;
      end
    end
    en = ($urandom_range(9) != 0);
    if ($urandom_range(63) == 0) wc = ~wc;
    if ($urandom_range(99) == 0) cfg_period = PeriodW'($urandom_range(30));
    if ($urandom_range(19) == 0)
      cfg_budget[$urandom_range(NumReq-1)*BudgetW +: BudgetW] = BudgetW'($urandom_range(24));
  endtask

  initial begin
    en = 1'b1; wc = 1'b0; beat = 1'b0; last = 1'b0; req = '0; len = '0;
    cfg_period = PeriodW'(100);
    cfg_budget = {NumReq{BudgetW'(64)}};
    #1 rst = 1'b1;

    // Basic grant and charge.
    do_reset();
    tick("basic_refill");
    req[3] = 1'b1; len[3*LenW +: LenW] = 8'd7;
    tick("basic_req");
    check_eq("basic_gnt", BV'(gnt), BV'(11'h008));
    beat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      last = (i == 7);
      tick("basic_beat");
    end
    beat = 1'b0; last = 1'b0; req[3] = 1'b0;
    check_eq("basic_budget", BV'(budget[3*BudgetW +: BudgetW]), BV'(56));
    check_eq("basic_release", BV'(gnt_valid), BV'(0));
    tick("basic_idle");

    // Round-robin order with wrap from 10 back to 0.
    do_reset();
    tick("rr_refill");
    req = 11'b10000010001; len = '0;
    tick("rr_first");
    for (int k = 0; k < 4; k++) begin
      check_eq("rr_order", BV'(gnt_idx), BV'(rr_exp[k]));
      check_eq("rr_valid", BV'(gnt_valid), BV'(1));
      beat = 1'b1; last = 1'b1;
      tick("rr_last");
      beat = 1'b0; last = 1'b0;
      tick("rr_next");
    end

    // Throttle until the refill raises the budget, then reset mid-burst.
    do_reset();
    cfg_period = PeriodW'(20);
    cfg_budget[2*BudgetW +: BudgetW] = BudgetW'(4);
    tick("thr_refill0");
    req[2] = 1'b1; len[2*LenW +: LenW] = 8'd7;
    tick("thr_req");
    check_eq("thr_flag", BV'(throttled[2]), BV'(1));
    check_eq("thr_nogrant", BV'(gnt_valid), BV'(0));
    cfg_budget[2*BudgetW +: BudgetW] = BudgetW'(64);
    for (int i = 0; i < 40 && budget[2*BudgetW +: BudgetW] != 16'd64; i++) tick("thr_wait");
    check_eq("thr_refill", BV'(budget[2*BudgetW +: BudgetW]), BV'(64));
    check_eq("thr_not_yet", BV'(gnt_valid), BV'(0));
    tick("thr_gnt_cycle");
    check_eq("thr_gnt", BV'(gnt), BV'(11'h004));
    beat = 1'b1;
    for (int i = 0; i < 3; i++) tick("arst_beat");
    #2 rst = 1'b1;
    #1;
    check_eq("arst_gnt", BV'(gnt), BV'(0));
    check_eq("arst_budget", budget, BV'(0));
    model_reset();
    check_outputs("arst");
    req = '0; beat = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick("arst_release");
    check_eq("arst_refill", BV'(budget[2*BudgetW +: BudgetW]), BV'(64));

    // Work-conserving bypass; budget saturates at zero.
    do_reset();
    cfg_period = PeriodW'(100);
    cfg_budget[2*BudgetW +: BudgetW] = BudgetW'(4);
    wc = 1'b1;
    tick("wc_refill");
    req[2] = 1'b1; len[2*LenW +: LenW] = 8'd7;
    tick("wc_req");
    check_eq("wc_gnt", BV'(gnt), BV'(11'h004));
    check_eq("wc_throttled", BV'(throttled[2]), BV'(1));
    beat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      last = (i == 7);
      tick("wc_beat");
    end
    beat = 1'b0; last = 1'b0; req[2] = 1'b0;
    check_eq("wc_saturate", BV'(budget[2*BudgetW +: BudgetW]), BV'(0));
    wc = 1'b0;
    cfg_budget[2*BudgetW +: BudgetW] = BudgetW'(64);

    // Beat on the refill cycle.
    do_reset();
    cfg_period = PeriodW'(3);
    tick("col_refill0");
    req[1] = 1'b1; len[1*LenW +: LenW] = 8'd15;
    tick("col_gnt");
    beat = 1'b1;
    tick("col_b1");
    tick("col_b2");
    tick("col_b3");
    check_eq("col_budget", BV'(budget[1*BudgetW +: BudgetW]), BV'(63));
    beat = 1'b0;

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < NumReq; n++) begin
      pend[n] = 0; plen[n] = 0;
    end
    beats_done = 0; last_sent = 0; rel_idx = 0;
    cfg_period = PeriodW'(12);
    for (int n = 0; n < NumReq; n++) cfg_budget[n*BudgetW +: BudgetW] = BudgetW'($urandom_range(24));
    for (int c = 0; c < 3000; c++) begin
      tick("rand");
      rand_drive();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
